// File: rtl/udp_frame_parser.sv
// Purpose: byte-serial Ethernet/IPv4/UDP parser. Hunts preamble+SFD, validates headers, streams UDP payload.
// Latency: payload byte and all status outputs appear one cycle after the accepted input byte.
// Backpressure: none. Only input_ready gates progress, and the consumer must take every payload byte.
//
// Ports:
//   main_clk, main_rst_n           clock, async active-low reset
//   eth_byte/input_ready/eth_last  MAC byte stream (eth_last only meaningful with input_ready)
//   valid_ip, valid_udp            level flags for the current frame
//   src_ip, dst_ip, src_port, dst_port, udp_len   header fields, held until the next frame overwrites them
//   payload_byte/_valid/_last      UDP payload stream
//   drop, drop_reason              one-cycle reject pulse; the reason is held until the next drop
module udp_frame_parser #(
  parameter int unsigned PREAMBLE_LEN   = 7,
  parameter bit          ALLOW_OPTIONS  = 1'b1,
  parameter bit          CHECK_CSUM     = 1'b1,
  parameter bit          PORT_FILTER_EN = 1'b0,
  parameter logic [15:0] PORT_MATCH     = 16'd0,
  parameter int unsigned MAX_FRAME      = 1518
) (
  input  logic        main_clk,
  input  logic        main_rst_n,
  input  logic [7:0]  eth_byte,
  input  logic        input_ready,
  input  logic        eth_last,
  output logic        valid_ip,
  output logic        valid_udp,
  output logic [31:0] src_ip,
  output logic [31:0] dst_ip,
  output logic [15:0] src_port,
  output logic [15:0] dst_port,
  output logic [15:0] udp_len,
  output logic [7:0]  payload_byte,
  output logic        payload_valid,
  output logic        payload_last,
  output logic        drop,
  output logic [2:0]  drop_reason
);

  localparam int          CW      = $clog2(MAX_FRAME + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_FRAME);
  localparam logic [3:0]  PRE_MIN = 4'(PREAMBLE_LEN);

  localparam logic [2:0] R_HDR   = 3'd1;
  localparam logic [2:0] R_IHL   = 3'd2;
  localparam logic [2:0] R_CSUM  = 3'd3;
  localparam logic [2:0] R_PROTO = 3'd4;
  localparam logic [2:0] R_PORT  = 3'd5;
  localparam logic [2:0] R_TRUNC = 3'd6;
  localparam logic [2:0] R_ULEN  = 3'd7;

  typedef enum logic [2:0] {HUNT, ETH_HDR, IP_HDR, UDP_HDR, PAYLOAD, SKIP} state_t;

  state_t          state_q, state_d;
  logic [3:0]      pre_cnt_q;
  logic [CW-1:0]   byte_cnt_q, byte_cnt_inc;
  logic [15:0]     sec_q;       // byte index within the current header/payload section
  logic [7:0]      eth_hi_q;
  logic [3:0]      ihl_q;
  logic [7:0]      proto_q;
  logic [7:0]      csum_hi_q;   // high byte of the IPv4 word being assembled
  logic [15:0]     csum_q, csum_d;
  logic [15:0]     csum_word;
  logic [16:0]     csum_sum;
  logic [15:0]     hdr_last;

  logic            drop_d;
  logic [2:0]      reason_d;
  logic            set_vip, set_vudp;
  logic            pay_emit, pay_last_d;

  always_comb begin
    state_d    = state_q;
    drop_d     = 1'b0;
    reason_d   = 3'd0;
    set_vip    = 1'b0;
    set_vudp   = 1'b0;
    pay_emit   = 1'b0;
    pay_last_d = 1'b0;

    // Ones-complement accumulate with the end-around carry folded on every word;
    // one fold suffices because two 16-bit values cannot carry twice.
    csum_word    = {csum_hi_q, eth_byte};
    csum_sum     = {1'b0, csum_q} + {1'b0, csum_word};
    csum_d       = csum_sum[15:0] + {15'd0, csum_sum[16]};
    hdr_last     = {10'd0, ihl_q, 2'b00} - 16'd1;
    byte_cnt_inc = byte_cnt_q + CW'(1);

    case (state_q)
      HUNT: begin
        if (eth_byte == 8'hD5 && pre_cnt_q >= PRE_MIN) state_d = ETH_HDR;
      end
      ETH_HDR: begin
        if (sec_q == 16'd13) begin
          if ({eth_hi_q, eth_byte} != 16'h0800) begin
            drop_d   = 1'b1;
            reason_d = R_HDR;
          end else begin
            state_d = IP_HDR;
          end
        end
      end
      IP_HDR: begin
        if (sec_q == 16'd0) begin
          if (eth_byte[7:4] != 4'd4) begin
            drop_d   = 1'b1;
            reason_d = R_HDR;
          end else if (eth_byte[3:0] < 4'd5 || (eth_byte[3:0] > 4'd5 && !ALLOW_OPTIONS)) begin
            drop_d   = 1'b1;
            reason_d = R_IHL;
          end
        end else if (sec_q == hdr_last) begin
          // Header length is always even, so the final byte completes the last word.
          if (CHECK_CSUM && csum_d != 16'hFFFF) begin
            drop_d   = 1'b1;
            reason_d = R_CSUM;
          end else if (proto_q != 8'd17) begin
            drop_d   = 1'b1;
            reason_d = R_PROTO;
          end else begin
            set_vip = 1'b1;
            state_d = UDP_HDR;
          end
        end
      end
      UDP_HDR: begin
        if (sec_q == 16'd7) begin
          if (udp_len < 16'd8) begin
            drop_d   = 1'b1;
            reason_d = R_ULEN;
          end else if (PORT_FILTER_EN && dst_port != PORT_MATCH) begin
            drop_d   = 1'b1;
            reason_d = R_PORT;
          end else begin
            set_vudp = 1'b1;
            state_d  = (udp_len == 16'd8) ? SKIP : PAYLOAD;
          end
        end
      end
      PAYLOAD: begin
        pay_emit   = 1'b1;
        pay_last_d = (sec_q + 16'd1 == udp_len - 16'd8);
        if (pay_last_d) state_d = eth_last ? HUNT : SKIP;
      end
      SKIP: begin
        if (eth_last) state_d = HUNT;
      end
      default: state_d = HUNT;
    endcase

    // Frame ended before the parser was done with it.
    if (eth_last && !drop_d &&
        (state_q == ETH_HDR || state_q == IP_HDR || state_q == UDP_HDR ||
         (state_q == PAYLOAD && !pay_last_d))) begin
      drop_d   = 1'b1;
      reason_d = R_TRUNC;
    end

    if (drop_d) begin
      set_vip  = 1'b0;
      set_vudp = 1'b0;
      state_d  = eth_last ? HUNT : SKIP;
    end else if (state_q != HUNT && state_d != HUNT && byte_cnt_inc == MAX_CNT) begin
      // Runaway frame: give up and resynchronise on the next preamble.
      drop_d   = 1'b1;
      reason_d = R_TRUNC;
      set_vip  = 1'b0;
      set_vudp = 1'b0;
      state_d  = HUNT;
    end
  end

  always_ff @(posedge main_clk or negedge main_rst_n) begin
    if (!main_rst_n) begin
      state_q       <= HUNT;
      pre_cnt_q     <= 4'd0;
      byte_cnt_q    <= '0;
      sec_q         <= 16'd0;
      eth_hi_q      <= 8'd0;
      ihl_q         <= 4'd0;
      proto_q       <= 8'd0;
      csum_hi_q     <= 8'd0;
      csum_q        <= 16'd0;
      valid_ip      <= 1'b0;
      valid_udp     <= 1'b0;
      src_ip        <= 32'd0;
      dst_ip        <= 32'd0;
      src_port      <= 16'd0;
      dst_port      <= 16'd0;
      udp_len       <= 16'd0;
      payload_byte  <= 8'd0;
      payload_valid <= 1'b0;
      payload_last  <= 1'b0;
      drop          <= 1'b0;
      drop_reason   <= 3'd0;
    end else begin
      payload_valid <= 1'b0;
      payload_last  <= 1'b0;
      drop          <= 1'b0;
      if (input_ready) begin
        state_q <= state_d;
        // Preamble run length only matters in HUNT; everywhere else it stays cleared.
        if (state_q == HUNT && eth_byte == 8'h55)
          pre_cnt_q <= (pre_cnt_q < PRE_MIN) ? pre_cnt_q + 4'd1 : pre_cnt_q;
        else
          pre_cnt_q <= 4'd0;
        byte_cnt_q <= (state_q == HUNT) ? '0 : byte_cnt_inc;
        sec_q      <= (state_q == HUNT || state_d != state_q) ? 16'd0 : sec_q + 16'd1;

        if (state_q == HUNT && state_d == ETH_HDR) begin
          valid_ip  <= 1'b0;
          valid_udp <= 1'b0;
          csum_q    <= 16'd0;
        end

        case (state_q)
          ETH_HDR: if (sec_q == 16'd12) eth_hi_q <= eth_byte;
          IP_HDR: begin
            if (sec_q[0]) csum_q <= csum_d;
            else          csum_hi_q <= eth_byte;
            if (sec_q == 16'd0) ihl_q <= eth_byte[3:0];
            if (sec_q == 16'd9) proto_q <= eth_byte;
            if (sec_q >= 16'd12 && sec_q <= 16'd15) src_ip <= {src_ip[23:0], eth_byte};
            if (sec_q >= 16'd16 && sec_q <= 16'd19) dst_ip <= {dst_ip[23:0], eth_byte};
          end
          UDP_HDR: begin
            if (sec_q <= 16'd1)                     src_port <= {src_port[7:0], eth_byte};
            if (sec_q == 16'd2 || sec_q == 16'd3)   dst_port <= {dst_port[7:0], eth_byte};
            if (sec_q == 16'd4 || sec_q == 16'd5)   udp_len  <= {udp_len[7:0], eth_byte};
          end
          default: ;
        endcase

        if (set_vip)  valid_ip  <= 1'b1;
        if (set_vudp) valid_udp <= 1'b1;
        if (drop_d) begin
          drop        <= 1'b1;
          drop_reason <= reason_d;
          valid_ip    <= 1'b0;
          valid_udp   <= 1'b0;
        end
        // A truncated payload byte is still forwarded, just without payload_last.
        if (pay_emit) begin
          payload_valid <= 1'b1;
          payload_byte  <= eth_byte;
          payload_last  <= pay_last_d;
        end
      end
    end
  end

endmodule

// File: doc/udp_frame_parser.md
Name: udp_frame_parser

Overview:
Parametrised successor to the byte-serial UDP detector. It hunts for preamble/SFD, then walks the Ethernet, IPv4 (with options) and UDP headers. It verifies the IPv4 header checksum, applies an optional destination-port filter, exports header fields and streams the UDP payload downstream. It sits between the MAC byte interface and the payload consumer, one byte per accepted cycle.

Parameters:
PREAMBLE_LEN, 7, minimum consecutive 0x55 bytes required before 0xD5 (1..15)
ALLOW_OPTIONS, 1, 1 = accept IHL 6..15 and skip option bytes; 0 = drop any IHL>5
CHECK_CSUM, 1, 1 = drop on bad IPv4 header checksum
PORT_FILTER_EN, 0, 1 = drop if UDP dst port != PORT_MATCH
PORT_MATCH, 16'd0, accepted UDP destination port
MAX_FRAME, 1518, byte-counter limit; counter width = $clog2(MAX_FRAME+1)

Ports:
main_clk  in  1  clock
main_rst_n  in  1  asynchronous active-low reset
eth_byte  in  8  frame byte
input_ready  in  1  eth_byte valid this cycle
eth_last  in  1  qualifies eth_byte as last byte of frame (ignored unless input_ready)
valid_ip  out  1  level: current frame passed all IPv4 checks
valid_udp  out  1  level: current frame passed UDP checks and port filter
src_ip  out  32  IPv4 source address
dst_ip  out  32  IPv4 destination address
src_port  out  16  UDP source port
dst_port  out  16  UDP destination port
udp_len  out  16  UDP length field
payload_byte  out  8  payload data
payload_valid  out  1  payload_byte valid
payload_last  out  1  final payload byte
drop  out  1  one-cycle pulse: frame rejected
drop_reason  out  3  cause, valid with drop, held until next drop

Behaviour:
- Reset (async, main_rst_n=0): state HUNT; all outputs 0; counters and checksum accumulator 0. Reset mid-frame abandons the frame with no drop pulse.
- Only cycles with input_ready=1 advance state/counters. payload_valid is 0 on any cycle following input_ready=0.
- States: HUNT, ETH_HDR, IP_HDR, UDP_HDR, PAYLOAD, SKIP.
- HUNT: pre_cnt counts consecutive 0x55, saturating at PREAMBLE_LEN. 0xD5 with pre_cnt>=PREAMBLE_LEN -> ETH_HDR, byte_cnt=0, valid_ip/valid_udp cleared. Any other byte: pre_cnt=0; 0x55 sets it to 1. eth_last ignored.
- ETH_HDR: 14 bytes. Bytes 12..13 are the ethertype. After byte 13: !=0x0800 -> drop reason 1.
- IP_HDR: byte 0 gives version/IHL; version!=4 -> reason 1. IHL<5, or IHL>5 with ALLOW_OPTIONS=0 -> reason 2. Length = IHL*4 bytes. Protocol (byte 9) is latched; src_ip = bytes 12..15, dst_ip = bytes 16..19. Option bytes are summed but not stored. Checksum: 16-bit big-endian words, ones-complement sum with end-around carry folded each word. After the last header byte, checks apply in this priority: sum!=16'hFFFF with CHECK_CSUM=1 -> reason 3; protocol!=17 -> reason 4; else valid_ip=1 on the next cycle.
- UDP_HDR: 8 bytes latched into src_port, dst_port, udp_len (checksum field ignored). After byte 7, in priority: udp_len<8 -> reason 7; PORT_FILTER_EN=1 and dst_port!=PORT_MATCH -> reason 5; else valid_udp=1. udp_len==8 -> SKIP, otherwise -> PAYLOAD.
- PAYLOAD: each accepted byte is registered to payload_byte with payload_valid=1 one cycle later (latency 1). payload_last accompanies byte number udp_len-8. After the last byte -> SKIP; if eth_last was on that same byte -> HUNT, no drop.
- SKIP: discard bytes (Ethernet padding/FCS) until eth_last, then -> HUNT. Preamble detection is disabled in SKIP.
- eth_last in ETH_HDR/IP_HDR/UDP_HDR, or before payload_last in PAYLOAD -> reason 6, -> HUNT. The truncated byte is still emitted as payload (payload_last=0).
- byte_cnt reaching MAX_FRAME in any non-HUNT state -> reason 6, -> HUNT.
- Drop: drop=1 for one cycle, the cycle after the offending byte. valid_ip/valid_udp are cleared. Next state is SKIP, or HUNT if the offending byte carried eth_last.
- Field outputs hold until overwritten by the next frame.

Test Plan:
- 7x0x55, 0xD5, ethertype 0x0800, IHL=5 header with correct checksum, proto 17, ports 1234->80, udp_len=12, payload DE AD BE EF, eth_last on last byte -> valid_ip, valid_udp=1; src_port=0x04D2, dst_port=0x0050; payload_valid for 4 cycles, payload_last on 0xEF; back to HUNT.
- Same frame with 6x0x55 before 0xD5 -> no state change, no outputs; preamble hunt continues.
- IHL=6 with a 4-byte option and correct checksum: ALLOW_OPTIONS=1 -> parsed, dst_ip correct; ALLOW_OPTIONS=0 -> drop, drop_reason=2.
- Header checksum off by one -> drop, drop_reason=3, valid_ip stays 0; with CHECK_CSUM=0 -> valid_udp=1.
- Ethertype 0x86DD -> drop_reason=1; proto 6 -> drop_reason=4; PORT_FILTER_EN=1, PORT_MATCH=80, dst_port 81 -> drop_reason=5. Each drop is followed by SKIP until eth_last.
- input_ready toggled 0/1 every cycle through a valid frame -> identical fields and payload. eth_last on UDP byte 3 -> drop_reason=6. Reset asserted mid-PAYLOAD -> all outputs 0 immediately, no drop.
